pulse_capture: RTL and testbench
================================

Name: pulse_capture

Overview:
- Downstream consumer of the `flipflop` stage output.
- Samples the single-bit registered output on `clk` and measures the width of every high pulse in clock cycles.
- Queues each measurement in a small FIFO, presented on a valid/ready stream to the next stage (status/debug logic).
- Flags saturation of the width counter and FIFO overflow.

Parameters:
- CNT_W, 8, width-counter bits; maximum reportable width is 2^CNT_W-1.
- FIFO_DEPTH, 4, number of queued measurements; power of 2, ≥2.

Ports:
- clk  input  1  system clock; all logic on its posedge.
- rst_n  input  1  synchronous active-low reset.
- in_sig  input  1  pulse stream; already synchronous to clk (driven by `flipflop.out`).
- m_valid  output  1  FIFO head holds a measurement.
- m_ready  input  1  consumer accepts head when m_valid&&m_ready at posedge.
- m_width  output  CNT_W  head measurement: high-cycle count.
- m_sat  output  1  head measurement saturated (true width ≥ 2^CNT_W-1).
- busy  output  1  a pulse is currently being measured (state MEASURE).
- overflow  output  1  sticky: a completed measurement was dropped because the FIFO was full.
- clr_ovf  input  1  clears overflow for one cycle.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n is sampled only at posedge clk: synchronous, active-low.
- Reset values:
  - state=ARM, cnt=0, FIFO empty (wr/rd pointers 0, count 0).
  - m_valid=0, m_width=0, m_sat=0, busy=0, overflow=0.
  - rst_n low mid-pulse discards the partial measurement and all queued entries.
- FSM, evaluated per posedge on sampled in_sig:
  - ARM: in_sig=0 -> IDLE; else stay. This prevents reporting a pulse already high when reset released.
  - IDLE: in_sig=1 -> MEASURE, cnt<=1; else stay.
  - MEASURE, in_sig=1: cnt<=cnt+1, saturating at 2^CNT_W-1; sat_flag<=1 when cnt reaches max.
  - MEASURE, in_sig=0: push {sat_flag,cnt} -> IDLE, clear sat_flag.
- Width semantics: a pulse high for N consecutive sampled edges reports m_width=N (N≥1).
- Latency:
  - The entry is pushed at the edge where in_sig is first sampled low.
  - m_valid rises immediately after that edge (1 cycle after the falling sample, 0 extra pipeline).
- Back-to-back pulses: after a push, IDLE is entered. A high sample on the next edge starts a new measurement, so a minimum 1-cycle low gap is resolved.
- FIFO:
  - Pop when m_valid&&m_ready.
  - m_width/m_sat reflect the head entry combinationally from the storage array and are stable while m_valid&&!m_ready.
  - Push when not full: accepted.
  - Push when full with a pop in the same cycle: accepted; count unchanged.
  - Push when full without a pop: entry dropped, overflow<=1.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Sticky; cleared by clr_ovf=1.
  - If a drop and clr_ovf occur in the same cycle, the set wins (overflow=1).
- busy = (state==MEASURE), registered-state decode.

Optional Feature:
- Macro: PULSE_CAPTURE_TIMEOUT_EN.
- Defined:
  - In MEASURE, on the edge where cnt would exceed 2^CNT_W-1, push {sat=1, width=2^CNT_W-1} immediately and go to ARM.
  - The remainder of the long pulse is ignored, so a stuck-high input produces exactly one entry.
- Undefined:
  - cnt holds at max with sat_flag=1 until in_sig falls.
  - The entry is pushed on the fall; a stuck-high input produces no entry.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1, with in_sig=0 -> m_valid=0, overflow=0, busy=0; first in_sig high starts MEASURE.
- Single-cycle pulse (in_sig high for 1 edge, m_ready=1) -> one entry, m_width=1, m_sat=0, m_valid high for 1 cycle the cycle after the fall.
- Two pulses of 3 and 2 cycles separated by 1 low cycle, m_ready=0 -> FIFO holds entries 3 then 2; raising m_ready pops 3 first, then 2.
- m_ready=0, five 1-cycle pulses with FIFO_DEPTH=4 -> 4 entries retained, overflow=1; clr_ovf pulse -> overflow=0; a push coinciding with a pop at full is accepted with no overflow.
- CNT_W=4, 20-cycle pulse:
  - Without macro -> entry width=15, sat=1, pushed after fall.
  - With PULSE_CAPTURE_TIMEOUT_EN -> entry width=15, sat=1, pushed at the 16th high edge; no further entry until in_sig low then high again.
- in_sig held high through reset release for 5 cycles -> no entry (ARM); after low then a 2-cycle pulse -> entry width=2.

Source files
------------

// File: rtl/pulse_capture.sv
// Measures the high width of each pulse on in_sig and queues results on a valid/ready stream.
// Optional PULSE_CAPTURE_TIMEOUT_EN: a saturated pulse is reported immediately and the rest ignored.
module pulse_capture #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_sig,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_width,
  output logic             m_sat,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_ARM     = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic             sat_q, sat_d;
  logic             busy_q;
  logic             push_c;
  logic [ENT_W-1:0] push_data_c;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             valid_q;
  logic             ovf_q;
  logic             pop_c, full_c, wr_en_c, drop_c;

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state and measurement datapath
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    push_c      = 1'b0;
    push_data_c = '0;
    case (state_q)
      ST_ARM: begin
        if (!in_sig) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_sig) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
          sat_d   = (CNT_MAX == CNT_W'(1));
        end
      end
      ST_MEASURE: begin
        if (in_sig) begin
          if (cnt_q == CNT_MAX) begin
`ifdef PULSE_CAPTURE_TIMEOUT_EN
            push_c      = 1'b1;
            push_data_c = {1'b1, CNT_MAX};
            state_d     = ST_ARM;
            cnt_d       = '0;
            sat_d       = 1'b0;
`else
            sat_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_inc_c;
            sat_d = (cnt_inc_c == CNT_MAX);
          end
        end else begin
          push_c      = 1'b1;
          push_data_c = {sat_q, cnt_q};
          state_d     = ST_IDLE;
          cnt_d       = '0;
          sat_d       = 1'b0;
        end
      end
      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      busy_q  <= (state_d == ST_MEASURE);
    end
  end

  // A push at full is still accepted when the head is popped in the same cycle
  assign pop_c   = valid_q && m_ready;
  assign full_c  = (count_q == DEPTH_C);
  assign wr_en_c = push_c && (!full_c || pop_c);
  assign drop_c  = push_c && full_c && !pop_c;

  always_comb begin
    count_d = count_q;
    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (drop_c)       ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  // Storage is cleared on reset so the head reads zero while empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q] <= push_data_c;
    end
  end

  assign m_valid  = valid_q;
  assign m_width  = mem_q[rd_ptr_q][CNT_W-1:0];
  assign m_sat    = mem_q[rd_ptr_q][CNT_W];
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Directed self-checking bench for pulse_capture (CNT_W=4, FIFO_DEPTH=4).
// Honours PULSE_CAPTURE_TIMEOUT_EN for the saturation scenario.
module tb_pulse_capture;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_sig;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_width;
  logic             m_sat;
  logic             busy;
  logic             overflow;
  logic             clr_ovf;

  int checks   = 0;
  int failures = 0;

  pulse_capture #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_sig   (in_sig),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_width  (m_width),
    .m_sat    (m_sat),
    .busy     (busy),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_sig = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%0b exp=0", m_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (m_width !== 4'd0 || m_sat !== 1'b0) begin failures++; $display("FAIL reset_head got=%0d/%0b exp=0/0", m_width, m_sat); end
    in_sig = 1'b1; tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_first_busy got=%0b exp=1", busy); end
    // Reset mid-pulse with an entry queued discards everything
    in_sig = 1'b0; tick();
    in_sig = 1'b1; tick();
    rst_n = 1'b0; tick();
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || m_width !== 4'd0) begin
      failures++; $display("FAIL reset_mid got=v%0b b%0b w%0d exp=v0 b0 w0", m_valid, busy, m_width);
    end
    rst_n = 1'b1; in_sig = 1'b0; tick();
  endtask

  task automatic test_single();
    do_reset();
    m_ready = 1'b1;
    in_sig = 1'b1; tick();
    checks++; if (busy !== 1'b1 || m_valid !== 1'b0) begin failures++; $display("FAIL single_meas got=b%0b v%0b exp=b1 v0", busy, m_valid); end
    in_sig = 1'b0; tick();
    checks++; if (m_valid !== 1'b1 || m_width !== 4'd1 || m_sat !== 1'b0) begin
      failures++; $display("FAIL single_entry got=v%0b w%0d s%0b exp=v1 w1 s0", m_valid, m_width, m_sat);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%0b exp=0", busy); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%0b exp=0", m_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_sig = 1'b1; tick(); tick(); tick();
    in_sig = 1'b0; tick();
    checks++; if (m_valid !== 1'b1 || m_width !== 4'd3) begin failures++; $display("FAIL b2b_first got=v%0b w%0d exp=v1 w3", m_valid, m_width); end
    in_sig = 1'b1; tick(); tick();
    in_sig = 1'b0; tick();
    checks++; if (m_width !== 4'd3) begin failures++; $display("FAIL b2b_head_stable got=%0d exp=3", m_width); end
    m_ready = 1'b1; tick();
    checks++; if (m_valid !== 1'b1 || m_width !== 4'd2) begin failures++; $display("FAIL b2b_second got=v%0b w%0d exp=v1 w2", m_valid, m_width); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b exp=0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_sig = 1'b1; tick();
      in_sig = 1'b0; tick();
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_full_no_drop got=%0b exp=0", overflow); end
    in_sig = 1'b1; tick();
    in_sig = 1'b0; tick();
    checks++; if (overflow !== 1'b1 || m_valid !== 1'b1) begin failures++; $display("FAIL ovf_set got=o%0b v%0b exp=o1 v1", overflow, m_valid); end
    clr_ovf = 1'b1; tick();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    // Push of a 2-wide pulse coincides with a pop while full
    in_sig = 1'b1; tick(); tick();
    in_sig = 1'b0; m_ready = 1'b1; tick();
    checks++; if (overflow !== 1'b0 || m_valid !== 1'b1) begin failures++; $display("FAIL ovf_push_pop got=o%0b v%0b exp=o0 v1", overflow, m_valid); end
    tick(); tick(); tick();
    checks++; if (m_valid !== 1'b1 || m_width !== 4'd2) begin failures++; $display("FAIL ovf_last_entry got=v%0b w%0d exp=v1 w2", m_valid, m_width); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0b exp=0", m_valid); end
    m_ready = 1'b0;
    // Drop and clear in the same cycle: set wins
    for (int i = 0; i < 4; i++) begin
      in_sig = 1'b1; tick();
      in_sig = 1'b0; tick();
    end
    in_sig = 1'b1; tick();
    in_sig = 1'b0; clr_ovf = 1'b1; tick();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%0b exp=1", overflow); end
  endtask

  task automatic test_saturation();
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin in_sig = 1'b1; tick(); end
    in_sig = 1'b0; tick();
    checks++; if (m_width !== 4'd14 || m_sat !== 1'b0) begin failures++; $display("FAIL sat_14 got=w%0d s%0b exp=w14 s0", m_width, m_sat); end
    m_ready = 1'b1; tick();
    m_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin in_sig = 1'b1; tick(); end
    in_sig = 1'b0; tick();
    checks++; if (m_valid !== 1'b1 || m_width !== 4'd15 || m_sat !== 1'b1) begin
      failures++; $display("FAIL sat_15 got=v%0b w%0d s%0b exp=v1 w15 s1", m_valid, m_width, m_sat);
    end
    m_ready = 1'b1; tick();
    m_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      in_sig = 1'b1; tick();
      if (i == 15) begin
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL sat_early got=%0b exp=0", m_valid); end
      end
      if (i == 16) begin
`ifdef PULSE_CAPTURE_TIMEOUT_EN
        checks++; if (m_valid !== 1'b1 || m_width !== 4'd15 || m_sat !== 1'b1 || busy !== 1'b0) begin
          failures++; $display("FAIL sat_timeout got=v%0b w%0d s%0b b%0b exp=v1 w15 s1 b0", m_valid, m_width, m_sat, busy);
        end
`else
        checks++; if (m_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL sat_hold got=v%0b b%0b exp=v0 b1", m_valid, busy); end
`endif
      end
    end
    in_sig = 1'b0; tick();
    checks++; if (m_valid !== 1'b1 || m_width !== 4'd15 || m_sat !== 1'b1) begin
      failures++; $display("FAIL sat_20 got=v%0b w%0d s%0b exp=v1 w15 s1", m_valid, m_width, m_sat);
    end
    m_ready = 1'b1; tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL sat_one_entry got=%0b exp=0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_arm();
    rst_n = 1'b0; in_sig = 1'b1; m_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL arm_ignore got=v%0b b%0b exp=v0 b0", m_valid, busy); end
    in_sig = 1'b0; tick();
    in_sig = 1'b1; tick(); tick();
    in_sig = 1'b0; tick();
    checks++; if (m_valid !== 1'b1 || m_width !== 4'd2 || m_sat !== 1'b0) begin
      failures++; $display("FAIL arm_pulse got=v%0b w%0d s%0b exp=v1 w2 s0", m_valid, m_width, m_sat);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_sig = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_saturation();
    test_arm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
